// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control FSM: memory ready handshake with wait timeout, run/stall, bne/halt/illegal.
// State codes follow declaration order (FETCH=0 .. HALT=15). Optional perf counters: MCCTRL_PERF_CNT_EN.
module multicycle_ctrl_fsm #(
  parameter int OP_W     = 6,
  parameter int ALUOP_W  = 4,
  parameter int WAIT_MAX = 15,
  parameter int STATE_W  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [OP_W-1:0]    op_in,
  input  logic               mem_ready,
  output logic [STATE_W-1:0] state,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         MemtoReg,
  output logic               RegWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               ReadSel,
  output logic               BranchNe,
  output logic               halted,
  output logic               illegal_op,
  output logic               mem_timeout
`ifdef MCCTRL_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        retired_cnt
`endif
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_ZE, S_EXEC_SE, S_WB, S_JUMP, S_BRANCH,
    S_IMM, S_LI_WB, S_LUI_WB, S_MEM_RD, S_LD_WB, S_MEM_WR, S_ILLEGAL, S_HALT
  } state_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(4'b0010);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(4'b0011);
  localparam logic [ALUOP_W-1:0] ALU_IMM = ALUOP_W'(4'b0100);

  state_t       r_state;
  state_t       w_next;
  logic [7:0]   r_wcnt;
  logic [5:0]   w_op6;
  logic         w_hi_ok;
  logic         w_wait_st;
  logic         w_timeout;

  assign w_op6 = op_in[5:0];

  // Opcodes wider than the map are only legal with zero upper bits.
  if (OP_W > 6) begin : g_hi
    assign w_hi_ok = ~|op_in[OP_W-1:6];
  end else begin : g_nohi
    assign w_hi_ok = 1'b1;
  end

  assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_timeout = w_wait_st && !mem_ready && (r_wcnt == 8'(WAIT_MAX));
  assign state     = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        w_next = S_ILLEGAL;
        if (w_hi_ok) begin
          casez (w_op6)
            6'b000000:                     w_next = S_FETCH;
            6'b010???:                     w_next = S_EXEC_R;
            6'b000001:                     w_next = S_JUMP;
            6'b10000?:                     w_next = S_BRANCH;
            6'b110100, 6'b110101, 6'b110111: w_next = S_EXEC_ZE;
            6'b110010, 6'b110011:          w_next = S_EXEC_SE;
            6'b111001, 6'b111010,
            6'b111011, 6'b111100:          w_next = S_IMM;
            6'b111111:                     w_next = S_HALT;
            default:                       w_next = S_ILLEGAL;
          endcase
        end
      end
      S_EXEC_R, S_EXEC_ZE, S_EXEC_SE: w_next = S_WB;
      S_IMM: begin
        case (w_op6)
          6'b111001: w_next = S_LI_WB;
          6'b111010: w_next = S_LUI_WB;
          6'b111011: w_next = S_MEM_RD;
          6'b111100: w_next = S_MEM_WR;
          default:   w_next = S_ILLEGAL;
        endcase
      end
      S_MEM_RD: begin
        if (mem_ready)      w_next = S_LD_WB;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_MEM_WR: if (mem_ready || w_timeout) w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  // Timeout refetch stays in FETCH, so the counter must also clear on expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_wcnt  <= '0;
    end else if (run) begin
      r_state <= w_next;
      if ((w_next != r_state) || w_timeout) r_wcnt <= '0;
      else if (w_wait_st && !mem_ready)     r_wcnt <= r_wcnt + 8'd1;
    end
  end

  always_comb begin
    ALUOp       = '0;
    PCSource    = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    MemtoReg    = 2'b00;
    RegWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    ReadSel     = 1'b0;
    BranchNe    = 1'b0;
    halted      = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          ALUOp   = ALU_ADD;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE:  begin ALUSrcB = 2'b10; ALUOp = ALU_ADD; end
        S_EXEC_R:  begin ALUSrcA = 2'b01; ALUSrcB = 2'b00; ALUOp = op_in[ALUOP_W-1:0]; end
        S_EXEC_ZE: begin ALUSrcA = 2'b01; ALUSrcB = 2'b11; ALUOp = op_in[ALUOP_W-1:0]; end
        S_EXEC_SE: begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; ALUOp = op_in[ALUOP_W-1:0]; end
        S_WB:      RegWrite = 1'b1;
        S_JUMP:    begin PCWrite = 1'b1; PCSource = 2'b10; end
        S_BRANCH: begin
          ALUSrcA     = 2'b01;
          ALUOp       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          BranchNe    = op_in[0];
        end
        S_IMM:     begin ALUSrcA = 2'b10; ALUSrcB = 2'b11; ALUOp = ALU_IMM; end
        S_LI_WB:   begin RegWrite = 1'b1; MemtoReg = 2'b10; end
        S_LUI_WB:  begin RegWrite = 1'b1; MemtoReg = 2'b11; end
        S_MEM_RD:  begin MemRead = 1'b1; ReadSel = 1'b1; end
        S_LD_WB:   begin RegWrite = 1'b1; MemtoReg = 2'b01; end
        S_MEM_WR:  begin MemWrite = !w_timeout; ReadSel = 1'b1; end
        S_ILLEGAL: illegal_op = 1'b1;
        S_HALT:    halted = 1'b1;
        default:   ;
      endcase
      mem_timeout = w_timeout;
      // A stalled cycle must not pulse or write; pulses re-fire once run resumes.
      if (!run) begin
        RegWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
      end
    end
  end

`ifdef MCCTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else if (run) begin
      if (r_state != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if ((w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_ILLEGAL) && !w_timeout)
        retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm (WAIT_MAX=4): expected output vectors queued per cycle.
module tb_multicycle_ctrl_fsm;
  localparam logic [4:0] S_FETCH = 5'd0, S_DEC = 5'd1, S_EXR = 5'd2, S_EXZE = 5'd3, S_EXSE = 5'd4,
                         S_WB = 5'd5, S_JMP = 5'd6, S_BR = 5'd7, S_IMM = 5'd8, S_LI = 5'd9,
                         S_LUI = 5'd10, S_MRD = 5'd11, S_LDWB = 5'd12, S_MWR = 5'd13,
                         S_ILL = 5'd14, S_HALT = 5'd15;
  // Strobe order: RegWrite, IRWrite, PCWrite, PCWriteCond, MemWrite, MemRead
  localparam logic [5:0] RW = 6'b100000, IRW = 6'b010000, PCW = 6'b001000,
                         PCWC = 6'b000100, MW = 6'b000010, MR = 6'b000001, NS = 6'b000000;
  // Flag order: ReadSel, BranchNe, halted, illegal_op, mem_timeout
  localparam logic [4:0] F0 = 5'b00000, FRS = 5'b10000, FBNE = 5'b01000, FH = 5'b00100,
                         FILL = 5'b00010, FTO = 5'b00001;

  logic clk = 1'b0, reset, run, mem_ready;
  logic [5:0] op_in;
  logic [4:0] state;
  logic [3:0] ALUOp;
  logic [1:0] PCSource, ALUSrcA, ALUSrcB, MemtoReg;
  logic RegWrite, IRWrite, PCWrite, PCWriteCond, MemWrite, MemRead;
  logic ReadSel, BranchNe, halted, illegal_op, mem_timeout;

  multicycle_ctrl_fsm #(.OP_W(6), .ALUOP_W(4), .WAIT_MAX(4), .STATE_W(5)) dut (
    .clk(clk), .reset(reset), .run(run), .op_in(op_in), .mem_ready(mem_ready),
    .state(state), .ALUOp(ALUOp), .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .MemWrite(MemWrite), .MemRead(MemRead), .ReadSel(ReadSel),
    .BranchNe(BranchNe), .halted(halted), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  logic [27:0] w_obs;
  assign w_obs = {state, ALUOp, PCSource, ALUSrcA, ALUSrcB, MemtoReg,
                  RegWrite, IRWrite, PCWrite, PCWriteCond, MemWrite, MemRead,
                  ReadSel, BranchNe, halted, illegal_op, mem_timeout};

  logic [27:0] exp_q[$];
  logic [27:0] obs_q[$];
  int checks = 0;
  int errors = 0;
  logic [27:0] v_fgo, v_fw, v_dec, v_rst;

  function automatic logic [27:0] e(input logic [4:0] st, input logic [3:0] alu,
                                    input logic [1:0] pcs, input logic [1:0] a,
                                    input logic [1:0] b, input logic [1:0] m2r,
                                    input logic [5:0] stb, input logic [4:0] fl);
    return {st, alu, pcs, a, b, m2r, stb, fl};
  endfunction

  // One clock: drive inputs, queue the expectation, capture the DUT at the falling edge.
  task automatic cyc(input logic rst, input logic r, input logic rdy, input logic [5:0] o,
                     input logic [27:0] ex);
    reset = rst; run = r; mem_ready = rdy; op_in = o;
    exp_q.push_back(ex);
    @(negedge clk);
    obs_q.push_back(w_obs);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [27:0] ex, ob;
    cyc(1'b1, 1'b1, 1'b1, 6'b010010, v_rst);
    cyc(1'b1, 1'b0, 1'b1, 6'b111111, v_rst);
    cyc(1'b0, 1'b1, 1'b0, 6'b000000, v_fw);
    for (int i = 0; exp_q.size() > 0; i++) begin
      ex = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (ob !== ex) begin errors++; $display("FAIL reset[%0d] got=%h want=%h", i, ob, ex); end
    end
  endtask

  task automatic test_rtype();
    logic [27:0] ex, ob;
    logic [5:0] op = 6'b010010;
    cyc(1'b1, 1'b1, 1'b0, op, v_rst);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b1, 1'b1, op, v_fgo);
      cyc(1'b0, 1'b1, 1'b1, op, v_dec);
      cyc(1'b0, 1'b1, 1'b1, op, e(S_EXR, 4'b0010, 2'b00, 2'b01, 2'b00, 2'b00, NS, F0));
      if (k == 0) cyc(1'b0, 1'b1, 1'b1, op, e(S_WB, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, RW, F0));
    end
    // Reset lands while in WB: strobe dropped that same cycle, then FETCH.
    cyc(1'b1, 1'b1, 1'b1, op, e(S_WB, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, NS, F0));
    cyc(1'b0, 1'b1, 1'b0, op, v_fw);
    for (int i = 0; exp_q.size() > 0; i++) begin
      ex = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (ob !== ex) begin errors++; $display("FAIL rtype[%0d] got=%h want=%h", i, ob, ex); end
    end
  endtask

  task automatic test_lwi_wait();
    logic [27:0] ex, ob;
    logic [5:0] op = 6'b111011;
    logic [27:0] v_mrd = e(S_MRD, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, MR, FRS);
    cyc(1'b1, 1'b1, 1'b0, op, v_rst);
    cyc(1'b0, 1'b1, 1'b1, op, v_fgo);
    cyc(1'b0, 1'b1, 1'b1, op, v_dec);
    cyc(1'b0, 1'b1, 1'b1, op, e(S_IMM, 4'b0100, 2'b00, 2'b10, 2'b11, 2'b00, NS, F0));
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, op, v_mrd);
    cyc(1'b0, 1'b1, 1'b1, op, v_mrd);
    cyc(1'b0, 1'b1, 1'b0, op, e(S_LDWB, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b01, RW, F0));
    cyc(1'b0, 1'b1, 1'b0, op, v_fw);
    for (int i = 0; exp_q.size() > 0; i++) begin
      ex = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (ob !== ex) begin errors++; $display("FAIL lwi[%0d] got=%h want=%h", i, ob, ex); end
    end
  endtask

  task automatic test_timeout();
    logic [27:0] ex, ob;
    cyc(1'b1, 1'b1, 1'b0, 6'b000000, v_rst);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b0, 6'b000000, v_fw);
    cyc(1'b0, 1'b1, 1'b0, 6'b000000, v_fw | 28'(FTO));
    // Counter restarts; ready on the expiry cycle wins over the timeout.
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b0, 6'b000000, v_fw);
    cyc(1'b0, 1'b1, 1'b1, 6'b000000, v_fgo);
    cyc(1'b0, 1'b1, 1'b1, 6'b000000, v_dec);
    cyc(1'b0, 1'b1, 1'b0, 6'b000000, v_fw);
    for (int i = 0; exp_q.size() > 0; i++) begin
      ex = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (ob !== ex) begin errors++; $display("FAIL timeout[%0d] got=%h want=%h", i, ob, ex); end
    end
  endtask

  task automatic test_branch();
    logic [27:0] ex, ob;
    cyc(1'b1, 1'b1, 1'b0, 6'b100001, v_rst);
    for (int k = 0; k < 2; k++) begin
      logic [5:0] op = (k == 0) ? 6'b100001 : 6'b100000;
      cyc(1'b0, 1'b1, 1'b1, op, v_fgo);
      cyc(1'b0, 1'b1, 1'b1, op, v_dec);
      cyc(1'b0, 1'b1, 1'b1, op, e(S_BR, 4'b0011, 2'b01, 2'b01, 2'b00, 2'b00, PCWC,
                                 (k == 0) ? FBNE : F0));
    end
    cyc(1'b0, 1'b1, 1'b0, 6'b100000, v_fw);
    for (int i = 0; exp_q.size() > 0; i++) begin
      ex = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (ob !== ex) begin errors++; $display("FAIL branch[%0d] got=%h want=%h", i, ob, ex); end
    end
  endtask

  task automatic test_misc_ops();
    logic [27:0] ex, ob;
    cyc(1'b1, 1'b1, 1'b0, 6'b000001, v_rst);
    cyc(1'b0, 1'b1, 1'b1, 6'b000001, v_fgo);
    cyc(1'b0, 1'b1, 1'b1, 6'b000001, v_dec);
    cyc(1'b0, 1'b1, 1'b1, 6'b000001, e(S_JMP, 4'b0000, 2'b10, 2'b00, 2'b00, 2'b00, PCW, F0));
    cyc(1'b0, 1'b1, 1'b1, 6'b111001, v_fgo);
    cyc(1'b0, 1'b1, 1'b1, 6'b111001, v_dec);
    cyc(1'b0, 1'b1, 1'b1, 6'b111001, e(S_IMM, 4'b0100, 2'b00, 2'b10, 2'b11, 2'b00, NS, F0));
    cyc(1'b0, 1'b1, 1'b1, 6'b111001, e(S_LI, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b10, RW, F0));
    cyc(1'b0, 1'b1, 1'b1, 6'b111010, v_fgo);
    cyc(1'b0, 1'b1, 1'b1, 6'b111010, v_dec);
    cyc(1'b0, 1'b1, 1'b1, 6'b111010, e(S_IMM, 4'b0100, 2'b00, 2'b10, 2'b11, 2'b00, NS, F0));
    cyc(1'b0, 1'b1, 1'b1, 6'b111010, e(S_LUI, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b11, RW, F0));
    cyc(1'b0, 1'b1, 1'b1, 6'b110101, v_fgo);
    cyc(1'b0, 1'b1, 1'b1, 6'b110101, v_dec);
    cyc(1'b0, 1'b1, 1'b1, 6'b110101, e(S_EXZE, 4'b0101, 2'b00, 2'b01, 2'b11, 2'b00, NS, F0));
    cyc(1'b0, 1'b1, 1'b1, 6'b110101, e(S_WB, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, RW, F0));
    cyc(1'b0, 1'b1, 1'b1, 6'b110011, v_fgo);
    cyc(1'b0, 1'b1, 1'b1, 6'b110011, v_dec);
    cyc(1'b0, 1'b1, 1'b1, 6'b110011, e(S_EXSE, 4'b0011, 2'b00, 2'b01, 2'b10, 2'b00, NS, F0));
    cyc(1'b0, 1'b1, 1'b1, 6'b110011, e(S_WB, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, RW, F0));
    cyc(1'b0, 1'b1, 1'b0, 6'b110011, v_fw);
    for (int i = 0; exp_q.size() > 0; i++) begin
      ex = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (ob !== ex) begin errors++; $display("FAIL misc[%0d] got=%h want=%h", i, ob, ex); end
    end
  endtask

  task automatic test_stall();
    logic [27:0] ex, ob;
    logic [5:0] op = 6'b111100;
    cyc(1'b1, 1'b1, 1'b0, op, v_rst);
    cyc(1'b0, 1'b1, 1'b1, op, v_fgo);
    cyc(1'b0, 1'b1, 1'b1, op, v_dec);
    cyc(1'b0, 1'b1, 1'b1, op, e(S_IMM, 4'b0100, 2'b00, 2'b10, 2'b11, 2'b00, NS, F0));
    cyc(1'b0, 1'b1, 1'b0, op, e(S_MWR, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, MW, FRS));
    for (int k = 0; k < 5; k++)
      cyc(1'b0, 1'b0, 1'(k % 2), op, e(S_MWR, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, NS, FRS));
    cyc(1'b0, 1'b1, 1'b1, op, e(S_MWR, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, MW, FRS));
    cyc(1'b0, 1'b0, 1'b1, op, e(S_FETCH, 4'b0010, 2'b00, 2'b00, 2'b01, 2'b00, NS, F0));
    cyc(1'b0, 1'b1, 1'b0, op, v_fw);
    for (int i = 0; exp_q.size() > 0; i++) begin
      ex = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (ob !== ex) begin errors++; $display("FAIL stall[%0d] got=%h want=%h", i, ob, ex); end
    end
  endtask

  task automatic test_illegal_halt();
    logic [27:0] ex, ob;
    logic [27:0] v_halt = e(S_HALT, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, NS, FH);
    cyc(1'b1, 1'b1, 1'b0, 6'b101010, v_rst);
    cyc(1'b0, 1'b1, 1'b1, 6'b101010, v_fgo);
    cyc(1'b0, 1'b1, 1'b1, 6'b101010, v_dec);
    cyc(1'b0, 1'b1, 1'b1, 6'b101010, e(S_ILL, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, NS, FILL));
    cyc(1'b0, 1'b1, 1'b1, 6'b111111, v_fgo);
    cyc(1'b0, 1'b1, 1'b1, 6'b111111, v_dec);
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 6'b111111, v_halt);
    cyc(1'b1, 1'b1, 1'b1, 6'b111111, e(S_HALT, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, NS, F0));
    cyc(1'b0, 1'b1, 1'b0, 6'b111111, v_fw);
    for (int i = 0; exp_q.size() > 0; i++) begin
      ex = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (ob !== ex) begin errors++; $display("FAIL illhalt[%0d] got=%h want=%h", i, ob, ex); end
    end
  endtask

  initial begin
    v_fgo = e(S_FETCH, 4'b0010, 2'b00, 2'b00, 2'b01, 2'b00, IRW | PCW | MR, F0);
    v_fw  = e(S_FETCH, 4'b0010, 2'b00, 2'b00, 2'b01, 2'b00, MR, F0);
    v_dec = e(S_DEC,   4'b0010, 2'b00, 2'b00, 2'b10, 2'b00, NS, F0);
    v_rst = 28'h0;
    reset = 1'b1; run = 1'b1; mem_ready = 1'b0; op_in = 6'b000000;
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_lwi_wait();
    test_timeout();
    test_branch();
    test_misc_ops();
    test_stall();
    test_illegal_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
